// File: rtl/bpc_et_if.sv
// Handshake/bus bundle for bpc_et: run control and configuration in, counter samples and status out.
interface bpc_et_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  logic                   start;
  logic [WIDTH-1:0]       mask;
  logic [NCH*WIDTH-1:0]   seed;
  logic [WIDTH:0]         len;
  logic [NCH-1:0]         ch_en;
  logic                   stall;
  logic                   abort;
  logic [NCH*WIDTH-1:0]   cnt;
  logic                   valid;
  logic [NCH-1:0]         ovf;
  logic                   busy;
  logic                   done;

  modport master (
    output start, mask, seed, len, ch_en, stall, abort,
    input  cnt, valid, ovf, busy, done
  );

  modport slave (
    input  start, mask, seed, len, ch_en, stall, abort,
    output cnt, valid, ovf, busy, done
  );
endinterface

// File: rtl/bpc_et.sv
// Multi-channel masked-increment counter with start/done sequencing and early termination.
// Optional macro BPC_ET_BITREV_EN presents each channel's counter bit-reversed on cnt.
module bpc_et #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  bpc_et_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH:0] K_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH:0]   r_len;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH:0]   r_k;

  logic             w_step;
  logic             w_last;
  logic             w_load;
  logic [WIDTH:0]   w_s_inc;

  // Returns {wrap, next value}; masked positions hold and pass the carry through.
  function automatic logic [WIDTH:0] masked_inc(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] c;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = c[i] & (v[i] | m[i]);
    end
    return {c[WIDTH], v ^ (c[WIDTH-1:0] & ~m)};
  endfunction

  assign w_load  = (r_state == S_IDLE) && bus.start;
  assign w_step  = (r_state == S_RUN) && !bus.stall && !bus.abort;
  assign w_s_inc = masked_inc(r_s, r_mask);
  assign w_last  = (r_len != '0) ? (r_k == (r_len - K_ONE)) : w_s_inc[WIDTH];

  assign bus.valid = w_step;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_len   <= '0;
      r_s     <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_mask  <= bus.mask;
            r_len   <= bus.len;
            r_s     <= '0;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          // abort outranks both stall and termination
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else if (!bus.stall) begin
            r_s <= w_s_inc[WIDTH-1:0];
            r_k <= r_k + K_ONE;
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] r_v;
      logic [WIDTH:0]   w_inc;

      assign w_inc = masked_inc(r_v, r_mask);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= '0;
        end else if (w_load) begin
          r_v <= bus.seed[gi*WIDTH +: WIDTH] & ~bus.mask;
        end else if (w_step && bus.ch_en[gi]) begin
          r_v <= w_inc[WIDTH-1:0];
        end
      end

      assign bus.ovf[gi] = w_step & bus.ch_en[gi] & w_inc[WIDTH];

`ifdef BPC_ET_BITREV_EN
      for (genvar bi = 0; bi < WIDTH; bi++) begin : g_rev
        assign bus.cnt[gi*WIDTH + bi] = r_v[WIDTH-1-bi];
      end
`else
      assign bus.cnt[gi*WIDTH +: WIDTH] = r_v;
`endif
    end
  endgenerate

endmodule

// File: doc/bpc_et.md
# bpc_et

Multi-channel masked-increment counter with start/done sequencing and early termination, the successor to the single-channel bit-parallel counter in the stochastic-number generation path. Each of NCH channels steps a WIDTH-bit counter whose masked bit positions never change and propagate carries. A run ends after a programmable number of steps, or after one full masked period, enabling progressive-precision early termination.

## Interface
- WIDTH, 8: counter width per channel.
- NCH, 4: channel count.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- mask  in  WIDTH  skipped bit positions (1 = held 0, carry-propagate); latched on accepted start.
- seed  in  NCH*WIDTH  per-channel initial value, channel c at [c*WIDTH +: WIDTH]; latched on accepted start.
- len  in  WIDTH+1  step count; 0 = one full masked period; latched on accepted start.
- ch_en  in  NCH  per-channel step enable; live, not latched.
- stall  in  1  freezes the run for the cycle.
- abort  in  1  ends a run without done.
- cnt  out  NCH*WIDTH  presented counter values.
- valid  out  1  cnt is a live sample this cycle.
- ovf  out  NCH  per-channel wrap flag.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start. Latch mask and len. Load each channel with seed & ~mask. Clear the internal step counter S.
- RUN -> DONE when the last step is taken. RUN -> IDLE on abort, which has priority over stall and termination.
- DONE -> IDLE unconditionally after one cycle.
- Masked increment, identical for every channel and for S:
  - carry[0] = 1.
  - carry[i+1] = carry[i] & (v[i] | mask[i]).
  - next v = v ^ (carry[WIDTH-1:0] & ~mask).
  - wrap = carry[WIDTH].
  - Masked bits never toggle. When all unmasked bits are 1, the value wraps to 0.
- Step: a RUN cycle with stall=0 and abort=0.
  - valid=1 on a step.
  - S advances on every step.
  - Channel c advances only on a step with ch_en[c]=1. Otherwise it holds its value and still presents it.
- Termination is evaluated on a step:
  - len != 0: the step is last when S (as an unmasked step count, tracked in a separate WIDTH+1-bit counter) equals len-1.
  - len == 0: the step is last when S's masked increment wraps. This gives 2^(WIDTH - popcount(mask)) steps.
- len greater than the period is legal. Channels wrap and continue.
- ovf[c] = valid & ch_en[c] & wrap_c, combinational from the presented value. It is set on the sample immediately before the wrap.
- start outside IDLE is ignored. mask, seed and len changes during RUN have no effect.
- All-ones mask: the period is 1, so len=0 gives one valid sample with value 0 and ovf high on enabled channels.

## Timing
- Reset values: state IDLE, all counters 0, cnt=0, valid=0, ovf=0, busy=0, done=0.
- Reset mid-run returns to IDLE next cycle with no done.
- start accepted at cycle t gives RUN at t+1. The first valid sample at t+1 is seed & ~mask.
- Sample k appears on the k-th unstalled RUN cycle. Throughput is one sample per cycle, and stall inserts bubbles.
- After the last valid sample at cycle u: done=1 and valid=0 at u+1, IDLE at u+2. The earliest next start is sampled at u+2.
- abort at cycle a: valid=0 at a, IDLE at a+1, done never asserts.
- cnt is registered state plus output mapping. valid, ovf and done are decoded from state with no extra latency.

## Configuration
- BPC_ET_BITREV_EN defined: each channel's cnt is the bit-reverse of its internal counter (bit i presented at WIDTH-1-i), giving low-discrepancy ordering. ovf, termination and S are unaffected.
- Undefined: cnt presents internal counters in natural order.

## Test plan
- WIDTH=4, NCH=1, mask=4'b0010, seed=0, len=0, start -> valid samples 0,1,4,5,8,9,12,13 on consecutive cycles; ovf only with 13; done the next cycle; then IDLE.
- WIDTH=4, mask=0, seed ch0=14, len=5 -> samples 14,15,0,1,2; ovf with 15; done after 5 valid cycles.
- Same run with stall high for 2 cycles after the 2nd sample and ch_en[1]=0 -> ch0 sequence unchanged but stretched by 2 cycles; ch1 holds its seed throughout; done delayed by 2.
- abort on the 3rd RUN cycle -> valid=0 that cycle, no done, busy=0 next cycle. A following start re-latches a new seed.
- mask=4'hF, len=0 -> exactly one sample with value 0, ovf=1, then done. Reset asserted mid-run with len=8 -> all outputs 0 next cycle.
- With BPC_ET_BITREV_EN, mask=0, len=4, seed=0 -> cnt 0,8,4,12.
